wallace_tree_mult: RTL and testbench
====================================

Name: wallace_tree_mult

Overview:
- 8x8 unsigned integer multiplier producing a full 16-bit product.
- Partial products are reduced by a Wallace tree of carry-save adders, followed by one carry-propagate adder.
- The result is registered with a valid flag so the block drops into the clocked datapath as a one-stage arithmetic unit.
- Used wherever an 8-bit multiply is needed without inferring the synthesis `*` operator.

Parameters:
- OUT_REG, default 1: 1 registers the product and valid (latency 1 cycle); 0 makes the result combinational (latency 0, valid passes through).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b are valid this cycle
- a  input  8  unsigned multiplicand
- b  input  8  unsigned multiplier
- out_valid  output  1  product is valid
- product  output  16  a*b, unsigned, full width, never truncated

Behaviour:
- Partial products: pp[i][j] = a[j] & b[i], for 64 bits total, placed at weight i+j.
- Reduction:
  - Wallace scheme: each stage groups column bits into threes (full adder) and leftover pairs (half adder) until every column holds at most 2 bits.
  - 8 rows reduce in 4 stages (8->6->4->3->2).
  - Carries go to column+1.
- Final step: a 16-bit ripple or prefix adder sums the two remaining rows.
- Any carry out of bit 15 is provably 0 (max 255*255 = 0xFE01) and is discarded.
- OUT_REG=1:
  - On each rising clk edge, product <= tree result of the current a/b, and out_valid <= in_valid.
  - product updates every cycle regardless of in_valid; consumers qualify it with out_valid.
- OUT_REG=0: product = tree result, out_valid = in_valid, both purely combinational. clk and rst are unused.
- Reset (OUT_REG=1):
  - rst high immediately (asynchronously) forces product = 16'h0000 and out_valid = 0.
  - Outputs hold these values while rst stays high.
  - The first capture happens on the first rising clk edge after rst deasserts.
  - Reset mid-stream drops the in-flight result; there is no recovery.
- No stalls or backpressure. Back-to-back in_valid yields one result per cycle.
- X on a/b must not propagate into out_valid.

Optional Feature:
- Macro: WALLACE_TREE_MULT_SIGNED_EN.
- When defined:
  - Adds input port `sgn` (1 bit, sampled with a/b).
  - sgn=1 treats a and b as two's-complement and produces a signed 16-bit product via Baugh-Wooley: invert the MSB cross-terms and add constant 1s at bits 8 and 15.
  - sgn=0 behaves exactly as unsigned.
- When undefined: no `sgn` port; unsigned only.
- Latency is the same in both cases.

Decomposition:
- Shared package wallace_pkg holds:
  - constants OP_W = 8 and PROD_W = 16;
  - the reduction-stage count localparam (4);
  - the Baugh-Wooley correction constant 16'h8100.
- Natural sub-module: wallace_fa (full adder: a, b, cin -> sum, cout).
  - Half adders are instantiated as wallace_fa with cin tied to 0, or written inline.
  - The final CPA stays in the top module.

Test Plan:
- rst=1 with a=8'hFF, b=8'hFF -> product=16'h0000, out_valid=0 throughout reset. Deassert rst, hold in_valid=0 one cycle -> out_valid=0.
- Single operations, in_valid=1, check one cycle later:
  - 00*00 -> 0000
  - FF*01 -> 00FF
  - 03*03 -> 0009
  - FF*03 -> 02FD
  - FF*FF -> FE01
  - AA*55 -> 3872
- Back-to-back in_valid for 4 cycles, a/b = (12,34), (80,02), (01,01), (7F,7F) -> consecutive products 03A8, 0100, 0001, 3F01, with out_valid high for exactly 4 cycles.
- Assert rst asynchronously (between edges) while out_valid=1 -> product and out_valid clear immediately, not at the next edge.
- Exhaustive sweep of all 65536 a/b pairs -> product == a*b for each. Also run with OUT_REG=0, checking a zero-cycle relationship.
- With WALLACE_TREE_MULT_SIGNED_EN, sgn=1:
  - 80*80 -> 4000
  - FF*01 -> FFFF
  - FF*FF -> 0001
  - 7F*80 -> C080

Source files
------------

// File: rtl/wallace_pkg.sv
// Shared constants for the 8x8 Wallace-tree multiplier.
// Holds operand/product widths, the reduction depth and the Baugh-Wooley
// correction constant used when WALLACE_TREE_MULT_SIGNED_EN is defined.
package wallace_pkg;

    localparam int OP_W       = 8;
    localparam int PROD_W     = 16;
    localparam int NUM_STAGES = 4;

    // Constant ones at bits 8 and 15 that complete a signed Baugh-Wooley array
    localparam logic [PROD_W-1:0] BW_CORR = 16'h8100;

    // Row count entering stage s: each stage turns groups of three rows into two
    // and passes the leftover rows through (8 -> 6 -> 4 -> 3 -> 2).
    function automatic int stage_rows(input int s);
        int n;
        n = OP_W;
        for (int k = 0; k < s; k++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

endpackage

// File: rtl/wallace_fa.sv
// One-bit full adder: the 3:2 compressor cell of the Wallace tree.
module wallace_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum is the parity of the inputs, carry is their majority
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/wallace_tree_mult.sv
// 8x8 multiplier: partial-product array, four-stage Wallace carry-save
// reduction, then a 16-bit ripple carry-propagate adder.
// OUT_REG=1 registers product/out_valid (latency 1); OUT_REG=0 is combinational.
// Optional macro WALLACE_TREE_MULT_SIGNED_EN adds the sgn port for signed
// (Baugh-Wooley) products; without it the block is unsigned only.
module wallace_tree_mult
    import wallace_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
`ifdef WALLACE_TREE_MULT_SIGNED_EN
    input  logic              sgn,
`endif
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    output logic [PROD_W-1:0] product
);

    logic sgn_eff;

`ifdef WALLACE_TREE_MULT_SIGNED_EN
    assign sgn_eff = sgn;
`else
    assign sgn_eff = 1'b0;
`endif

    // Rows alive at each level of the tree; level 0 is the partial-product
    // array, level NUM_STAGES holds the final two carry-save rows.
    logic [PROD_W-1:0] tree_rows [NUM_STAGES+1][OP_W];

    // Partial products: row gi is a & b[gi] shifted to weight gi. In signed
    // mode the cross-terms involving exactly one MSB are inverted and the
    // correction ones are dropped into free bit slots (row 0 bit 8, row 7 bit 15)
    // so the array stays eight rows deep.
    for (genvar gi = 0; gi < OP_W; gi++) begin : g_pp_row
        localparam logic [PROD_W-1:0] ROW_CORR =
            (gi == 0)        ? (BW_CORR & (PROD_W'(1) << OP_W)) :
            (gi == OP_W - 1) ? (BW_CORR & (PROD_W'(1) << (PROD_W - 1))) :
                               '0;
        logic [OP_W-1:0] pp_bits;

        for (genvar gj = 0; gj < OP_W; gj++) begin : g_pp_bit
            localparam logic INV = ((gi == OP_W - 1) != (gj == OP_W - 1));
            assign pp_bits[gj] = (a[gj] & b[gi]) ^ (sgn_eff & INV);
        end

        assign tree_rows[0][gi] = (PROD_W'(pp_bits) << gi) | (ROW_CORR & {PROD_W{sgn_eff}});
    end

    // Wallace reduction: each stage compresses row triples with full adders,
    // carries move one column up; leftover rows pass straight through. The
    // carry out of bit 15 is dropped since the product fits in 16 bits
    // (and signed results are defined modulo 2^16).
    for (genvar gs = 0; gs < NUM_STAGES; gs++) begin : g_stage
        localparam int N_IN  = stage_rows(gs);
        localparam int N_GRP = N_IN / 3;
        localparam int N_OUT = stage_rows(gs + 1);

        for (genvar gg = 0; gg < N_GRP; gg++) begin : g_csa
            logic [PROD_W-1:0] sum_row;
            logic [PROD_W-2:0] carry_row;

            for (genvar gb = 0; gb < PROD_W - 1; gb++) begin : g_bit
                wallace_fa u_fa (
                    .a    (tree_rows[gs][3*gg][gb]),
                    .b    (tree_rows[gs][3*gg+1][gb]),
                    .cin  (tree_rows[gs][3*gg+2][gb]),
                    .sum  (sum_row[gb]),
                    .cout (carry_row[gb])
                );
            end

            assign sum_row[PROD_W-1] = tree_rows[gs][3*gg][PROD_W-1]
                                     ^ tree_rows[gs][3*gg+1][PROD_W-1]
                                     ^ tree_rows[gs][3*gg+2][PROD_W-1];

            assign tree_rows[gs+1][2*gg]   = sum_row;
            assign tree_rows[gs+1][2*gg+1] = {carry_row, 1'b0};
        end

        for (genvar gl = 3 * N_GRP; gl < N_IN; gl++) begin : g_pass
            assign tree_rows[gs+1][gl - N_GRP] = tree_rows[gs][gl];
        end

        for (genvar gz = N_OUT; gz < OP_W; gz++) begin : g_empty
            assign tree_rows[gs+1][gz] = '0;
        end
    end

    logic [PROD_W-1:0] cpa_x;
    logic [PROD_W-1:0] cpa_y;
    logic [PROD_W-1:0] tree_sum;
    logic              cpa_carry;

    assign cpa_x = tree_rows[NUM_STAGES][0];
    assign cpa_y = tree_rows[NUM_STAGES][1];

    // Final carry-propagate adder: plain ripple over the two remaining rows
    always_comb begin
        tree_sum  = '0;
        cpa_carry = 1'b0;
        for (int k = 0; k < PROD_W; k++) begin
            tree_sum[k] = cpa_x[k] ^ cpa_y[k] ^ cpa_carry;
            cpa_carry   = (cpa_x[k] & cpa_y[k]) | (cpa_carry & (cpa_x[k] ^ cpa_y[k]));
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [PROD_W-1:0] product_d;
        logic [PROD_W-1:0] product_q;
        logic              out_valid_d;
        logic              out_valid_q;

        // Next state: product follows the tree every cycle, valid follows in_valid
        always_comb begin
            product_d   = tree_sum;
            out_valid_d = in_valid;
        end

        // Output register with asynchronous clear; in-flight result is dropped
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                product_q   <= '0;
                out_valid_q <= 1'b0;
            end else begin
                product_q   <= product_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign product   = product_q;
        assign out_valid = out_valid_q;
    end else begin : g_out_comb
        assign product   = tree_sum;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_wallace_tree_mult.sv
// Self-checking bench for wallace_tree_mult: directed table, back-to-back
// stream, asynchronous reset, randomized traffic and an exhaustive sweep,
// checking a registered instance and a combinational (OUT_REG=0) instance.
module tb_wallace_tree_mult;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic        out_valid;
    logic [15:0] product;
    logic        out_valid_c;
    logic [15:0] product_c;

    int checks;
    int errors;

    wallace_tree_mult #(.OUT_REG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
`ifdef WALLACE_TREE_MULT_SIGNED_EN
        .sgn       (sgn),
`endif
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .product   (product)
    );

    wallace_tree_mult #(.OUT_REG(0)) dut_c (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
`ifdef WALLACE_TREE_MULT_SIGNED_EN
        .sgn       (sgn),
`endif
        .a         (a),
        .b         (b),
        .out_valid (out_valid_c),
        .product   (product_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    // Behavioural reference: integer multiply, signed when s is set, kept modulo 2^16
    function automatic logic [15:0] ref_mult(input logic [7:0] x, input logic [7:0] y, input logic s);
        int sx;
        int sy;
        int p;
        sx = s ? int'($signed(x)) : int'(x);
        sy = s ? int'($signed(y)) : int'(y);
        p  = sx * sy;
        return p[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one operand pair at the falling edge, then check one cycle later
    task automatic run_op(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic s, input logic [15:0] exp);
        @(negedge clk);
        a = x; b = y; sgn = s; in_valid = 1'b1;
        #1;
        check({name, "_comb"}, {16'h0, product_c}, {16'h0, exp});
        @(posedge clk);
        #1;
        check(name, {16'h0, product}, {16'h0, exp});
        check({name, "_vld"}, {31'h0, out_valid}, 32'h1);
        $display("op %s a=%02h b=%02h sgn=%0b product=%04h", name, x, y, s, product);
    endtask

    vec_t tbl [6];
    vec_t stream [4];
    vec_t stbl [4];

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        sgn      = 1'b0;
        in_valid = 1'b1;

        tbl[0] = '{8'h00, 8'h00, 1'b0, 16'h0000};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        tbl[2] = '{8'h03, 8'h03, 1'b0, 16'h0009};
        tbl[3] = '{8'hFF, 8'h03, 1'b0, 16'h02FD};
        tbl[4] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        tbl[5] = '{8'hAA, 8'h55, 1'b0, 16'h3872};

        stream[0] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
        stream[1] = '{8'h80, 8'h02, 1'b0, 16'h0100};
        stream[2] = '{8'h01, 8'h01, 1'b0, 16'h0001};
        stream[3] = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};

        stbl[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        stbl[1] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        stbl[2] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        stbl[3] = '{8'h7F, 8'h80, 1'b1, 16'hC080};

        // Reset holds outputs at zero even with valid operands present
        #1;
        check("rst_prod_t0", {16'h0, product}, 32'h0);
        check("rst_vld_t0", {31'h0, out_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_prod_hold", {16'h0, product}, 32'h0);
        check("rst_vld_hold", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_vld", {31'h0, out_valid}, 32'h0);
        $display("op reset released out_valid=%0b", out_valid);

        // Directed single operations
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp);
        end

        // Back-to-back stream: one result per cycle, valid high exactly four cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = stream[i].a; b = stream[i].b; sgn = 1'b0; in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d", i), {16'h0, product}, {16'h0, stream[i].exp});
            check($sformatf("b2b%0d_vld", i), {31'h0, out_valid}, 32'h1);
            $display("op b2b%0d a=%02h b=%02h product=%04h", i, stream[i].a, stream[i].b, product);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_end_vld", {31'h0, out_valid}, 32'h0);

        // Asynchronous reset between edges clears outputs immediately
        @(negedge clk);
        a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("arst_pre_vld", {31'h0, out_valid}, 32'h1);
        check("arst_pre_prod", {16'h0, product}, 32'h03A8);
        #2;
        rst = 1'b1;
        #1;
        check("arst_prod", {16'h0, product}, 32'h0);
        check("arst_vld", {31'h0, out_valid}, 32'h0);
        $display("op async reset product=%04h out_valid=%0b", product, out_valid);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

`ifdef WALLACE_TREE_MULT_SIGNED_EN
        // Signed Baugh-Wooley products
        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("sgn%0d", i), stbl[i].a, stbl[i].b, stbl[i].s, stbl[i].exp);
        end
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            logic [7:0]  ra;
            logic [7:0]  rb;
            logic        rv;
            logic        rs;
            logic [15:0] exp;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rv = 1'($urandom);
`ifdef WALLACE_TREE_MULT_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            exp = ref_mult(ra, rb, rs);
            @(negedge clk);
            a = ra; b = rb; sgn = rs; in_valid = rv;
            #1;
            check("rnd_comb", {16'h0, product_c}, {16'h0, exp});
            check("rnd_comb_vld", {31'h0, out_valid_c}, {31'h0, rv});
            @(posedge clk);
            #1;
            check("rnd_prod", {16'h0, product}, {16'h0, exp});
            check("rnd_vld", {31'h0, out_valid}, {31'h0, rv});
        end

        // Exhaustive unsigned sweep on both instances
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] exp;
            exp = ref_mult(i[7:0], i[15:8], 1'b0);
            @(negedge clk);
            a = i[7:0]; b = i[15:8]; sgn = 1'b0; in_valid = 1'b1;
            #1;
            check("swp_comb", {i, product_c}, {i, exp});
            @(posedge clk);
            #1;
            check("swp_prod", {i, product}, {i, exp});
        end
        @(negedge clk);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
